// File: rtl/npu_cube_acc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | npu_cube_acc_ctrl: streams chunks into the cube add tree and accumulates  |
// | the extended tree results. Rev 1.0                                        |
// +--------------------------------------------------------------------------+
module npu_cube_acc_ctrl #(
    parameter int DWA      = 8,
    parameter int DWB_CODE = 12,
    parameter int MAC_NUM  = 8,
    parameter int DWOUT    = 19,
    parameter int DWACC    = 32,
    parameter int LEN_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_start,
    input  logic [LEN_W-1:0]            cfg_len,
    input  logic                        cfg_signed,
    output logic                        busy,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DWA*MAC_NUM-1:0]      in_data,
    input  logic [DWB_CODE*MAC_NUM-1:0] in_code,
    output logic [DWA*MAC_NUM-1:0]      tree_data,
    output logic [DWB_CODE*MAC_NUM-1:0] tree_code,
    output logic                        tree_is_signed,
    input  logic [DWOUT-1:0]            tree_result,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DWACC-1:0]            out_acc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t             state;
    logic [DWACC-1:0]   acc;
    logic [LEN_W-1:0]   remaining;
    logic               op_vld;
    logic               hs;
    logic [DWACC-1:0]   ext_result;
    logic [DWACC-1:0]   acc_sum;

    assign hs = in_valid & in_ready;

    generate
        if (DWACC > DWOUT) begin : g_ext_wide
            assign ext_result = {{(DWACC-DWOUT){tree_is_signed & tree_result[DWOUT-1]}},
                                 tree_result};
        end else begin : g_ext_equal
            assign ext_result = tree_result;
        end
    endgenerate

    // The operand registers hold their last value between accepts, so op_vld gates the add.
    assign acc_sum = op_vld ? (acc + ext_result) : acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            acc            <= '0;
            remaining      <= '0;
            op_vld         <= 1'b0;
            busy           <= 1'b0;
            in_ready       <= 1'b0;
            out_valid      <= 1'b0;
            out_acc        <= '0;
            tree_data      <= '0;
            tree_code      <= '0;
            tree_is_signed <= 1'b0;
        end else begin
            op_vld <= hs;
            acc    <= acc_sum;
            if (hs) begin
                tree_data <= in_data;
                tree_code <= in_code;
            end

            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        acc            <= '0;
                        remaining      <= cfg_len;
                        tree_is_signed <= cfg_signed;
                        busy           <= 1'b1;
                        if (cfg_len != '0) begin
                            state    <= S_RUN;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= S_OUT;
                            out_valid <= 1'b1;
                            out_acc   <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (hs) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            in_ready <= 1'b0;
                            state    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    state <= S_OUT;
                end
                S_OUT: begin
                    // First OUT cycle publishes the settled accumulator; later cycles wait for ready.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_acc   <= acc;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/npu_cube_acc_ctrl.md
# npu_cube_acc_ctrl

Sequencing controller for the NPU cube add tree. It accepts a dot-product job of `cfg_len` 8-lane chunks and streams the chunks, one per cycle, into the add tree's data/para-code operand ports. It sign- or zero-extends each 19-bit tree result and accumulates it into a wide accumulator. The final sum is returned through a valid/ready output handshake. It sits between the cube operand fetch stream and result writeback, and wraps one add-tree instance that is external to this block.

## Interface
- `DWA`, 8, data width per lane
- `DWB_CODE`, 12, para-code width per lane
- `MAC_NUM`, 8, lanes per chunk
- `DWOUT`, 19, add-tree result width
- `DWACC`, 32, accumulator width (≥ `DWOUT`)
- `LEN_W`, 8, chunk-count width

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: synchronous, active-low reset
- `cfg_start` in 1: job start pulse, honoured only in IDLE
- `cfg_len` in `LEN_W`: chunk count, sampled with `cfg_start`
- `cfg_signed` in 1: signed mode, sampled with `cfg_start`
- `busy` out 1: high in every state except IDLE
- `in_valid` in 1: chunk valid
- `in_ready` out 1: chunk ready
- `in_data` in `DWA*MAC_NUM`: chunk data
- `in_code` in `DWB_CODE*MAC_NUM`: chunk para codes
- `tree_data` out `DWA*MAC_NUM`: registered operand to the add tree
- `tree_code` out `DWB_CODE*MAC_NUM`: registered operand to the add tree
- `tree_is_signed` out 1: latched `cfg_signed`
- `tree_result` in `DWOUT`: combinational tree output for the current `tree_data`/`tree_code`
- `out_valid` out 1: result valid
- `out_ready` in 1: result ready
- `out_acc` out `DWACC`: accumulated result

## Operation
- FSM states: IDLE, RUN, DRAIN, OUT.
- **IDLE:** when `cfg_start` is high:
  - clear acc; load `remaining = cfg_len`; latch `tree_is_signed = cfg_signed`.
  - go to RUN if `cfg_len != 0`, otherwise go to OUT with acc = 0.
- **RUN:**
  - `in_ready = 1` while `remaining != 0`.
  - Each handshake (`in_valid & in_ready`) loads the `tree_data`/`tree_code` registers, sets `op_vld`, and decrements `remaining`.
  - The handshake that makes `remaining` reach 0 moves the FSM to DRAIN.
- **Accumulate:** on any edge with `op_vld = 1`, `acc += ext(tree_result)`.
  - ext = sign-extend from bit `DWOUT-1` when `tree_is_signed`, else zero-extend.
  - `op_vld` clears on any cycle with no handshake.
- **DRAIN:** exactly one cycle, in which the last chunk's product is accumulated. Then go to OUT.
- **OUT:**
  - `out_valid = 1` and `out_acc = acc`, held stable until `out_ready`.
  - On the handshake, go to IDLE.
- Accumulator wraps modulo 2^`DWACC`; no saturation.
- Operand registers hold their last value when no handshake occurs. The accumulator ignores them because `op_vld = 0`.
- `in_data`/`in_code` are ignored outside RUN handshakes.

## Timing
- Reset values: `in_ready` 0, `out_valid` 0, `busy` 0, `out_acc` 0, `tree_data` 0, `tree_code` 0, `tree_is_signed` 0. Internal: acc 0, `remaining` 0, `op_vld` 0, state IDLE.
- `cfg_start` at edge T → `busy` and (if `len != 0`) `in_ready` are high after T.
- Throughput: one chunk per cycle with `in_valid` held high. `in_ready` is a registered function of state and `remaining`, with no combinational path from `in_valid`.
- Latency: last chunk accepted at edge T → its tree result is accumulated at T+1 (DRAIN) → `out_valid` is high after T+2.
  - Minimum job length in cycles: `cfg_len + 2` from the first accept to `out_valid`.
- `len = 0`: `out_valid` is high the cycle after the start edge, with `out_acc = 0`.
- `in_valid` gaps insert idle cycles, with no effect on the result.
- `cfg_start` in a non-IDLE state is ignored, with no effect on the job.
- `out_ready` held low: stay in OUT indefinitely, with `out_acc` stable.
- `out_ready` and `cfg_start` in the same cycle: this cycle's start is not accepted, since the FSM is in OUT. IDLE is entered at the next edge.
- `rst_n` low mid-job: all state returns to reset values at that edge. The partial job is discarded and no `out_valid` is produced.

## Test plan
The bench drives `tree_result` from a stub that returns the sum of the 8 unsigned `tree_data` bytes, truncated to 19 bits.
- **Unsigned, back-to-back:** `cfg_len = 4`, `cfg_signed = 0`, four chunks with every byte = 1, 2, 3, 4, `in_valid` held high → `out_acc = 80`. `out_valid` asserts exactly 2 cycles after the 4th accept.
- **Signed extension:** the stub is forced to return 19'h7FFFF (−1) for 3 chunks, `cfg_signed = 1` → `out_acc = 32'hFFFFFFFD`. The same stimulus with `cfg_signed = 0` → `out_acc = 3 × 524287 = 1572861`.
- **Zero length:** `cfg_len = 0` → `out_valid` the next cycle, `out_acc = 0`, `in_ready` never asserts.
- **Stalls:**
  - `in_valid` toggled randomly across `cfg_len = 255` chunks of all-0xFF bytes → `out_acc = 255 × 2040 = 520200`.
  - `out_ready` held low for 10 cycles → `out_acc` stays stable.
  - `cfg_start` pulsed while busy → ignored.
- **Wrap:** `DWACC = 19`, `cfg_len = 2`, stub returns 19'h40000 twice, unsigned → `out_acc = 0`.
- **Reset mid-job:** `rst_n` low after 2 of 5 chunks → all outputs return to reset values. A fresh job then yields the correct result with no contamination from the aborted job.
